// File: rtl/pmem_adaptor_types.sv
// Shared types and constants for the cache-line <-> memory-burst adaptor.
package pmem_adaptor_types;
   localparam int LINE_WIDTH  = 256;
   localparam int BEAT_WIDTH  = 64;
   localparam int BEATS       = LINE_WIDTH / BEAT_WIDTH;
   localparam int OFFSET_BITS = 5;

   typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_e;
endpackage

// File: rtl/line_beat_buffer.sv
// One cache line of storage: full-line load, beat-indexed write for read
// assembly, beat-indexed read mux for write serialisation.
module line_beat_buffer #(
   parameter int LINE_WIDTH = 256,
   parameter int BEAT_WIDTH = 64,
   parameter int IDX_W      = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [LINE_WIDTH-1:0] load_line,
   input  logic                  beat_we,
   input  logic [IDX_W-1:0]      beat_widx,
   input  logic [BEAT_WIDTH-1:0] beat_wdata,
   input  logic [IDX_W-1:0]      beat_ridx,
   output logic [BEAT_WIDTH-1:0] beat_rdata,
   output logic [LINE_WIDTH-1:0] line
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         line <= '0;
      else if (load)
         line <= load_line;
      else if (beat_we)
         line[beat_widx*BEAT_WIDTH +: BEAT_WIDTH] <= beat_wdata;
   end

   assign beat_rdata = line[beat_ridx*BEAT_WIDTH +: BEAT_WIDTH];
endmodule

// File: rtl/pmem_burst_adaptor.sv
// Turns one cache line read/write into a 4-beat memory burst; one transaction
// in flight, completion signalled by a single-cycle pmem_resp.
module pmem_burst_adaptor
   import pmem_adaptor_types::*;
#(
   parameter int LINE_WIDTH = 256,
   parameter int BEAT_WIDTH = 64,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  pmem_read,
   input  logic                  pmem_write,
   input  logic [ADDR_WIDTH-1:0] pmem_address,
   input  logic [LINE_WIDTH-1:0] pmem_wdata,
   output logic                  pmem_resp,
   output logic [LINE_WIDTH-1:0] pmem_rdata,
   output logic                  burst_read,
   output logic                  burst_write,
   output logic [ADDR_WIDTH-1:0] burst_address,
   output logic [BEAT_WIDTH-1:0] burst_wdata,
   input  logic [BEAT_WIDTH-1:0] burst_rdata,
   input  logic                  burst_resp
);
   localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
   localparam int CNT_W = $clog2(BEATS);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

   state_e                  state;
   logic [CNT_W-1:0]        cnt;
   logic [CNT_W-1:0]        cnt_nxt;
   logic [LINE_WIDTH-1:0]   line_q;
   logic [LINE_WIDTH-1:0]   rd_line;
   logic [BEAT_WIDTH-1:0]   next_beat;
   logic [ADDR_WIDTH-1:0]   aligned_addr;

   assign cnt_nxt      = cnt + CNT_W'(1);
   assign aligned_addr = {pmem_address[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};

   line_beat_buffer #(
      .LINE_WIDTH (LINE_WIDTH),
      .BEAT_WIDTH (BEAT_WIDTH),
      .IDX_W      (CNT_W)
   ) u_buf (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (state == IDLE && pmem_write),
      .load_line  (pmem_wdata),
      .beat_we    (state == RD_BURST && burst_resp),
      .beat_widx  (cnt),
      .beat_wdata (burst_rdata),
      .beat_ridx  (cnt_nxt),
      .beat_rdata (next_beat),
      .line       (line_q)
   );

   // Final read beat is folded in here so pmem_rdata is complete on entry to DONE.
   always_comb begin
      rd_line = line_q;
      rd_line[cnt*BEAT_WIDTH +: BEAT_WIDTH] = burst_rdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         pmem_resp     <= 1'b0;
         pmem_rdata    <= '0;
         burst_read    <= 1'b0;
         burst_write   <= 1'b0;
         burst_address <= '0;
         burst_wdata   <= '0;
      end else begin
         case (state)
            IDLE: begin
               pmem_resp <= 1'b0;
               cnt       <= '0;
               if (pmem_write) begin
                  state         <= WR_BURST;
                  burst_write   <= 1'b1;
                  burst_address <= aligned_addr;
                  burst_wdata   <= pmem_wdata[BEAT_WIDTH-1:0];
               end else if (pmem_read) begin
                  state         <= RD_BURST;
                  burst_read    <= 1'b1;
                  burst_address <= aligned_addr;
               end
            end
            RD_BURST: if (burst_resp) begin
               cnt <= cnt_nxt;
               if (cnt == LAST) begin
                  state      <= DONE;
                  burst_read <= 1'b0;
                  pmem_resp  <= 1'b1;
                  pmem_rdata <= rd_line;
               end
            end
            WR_BURST: if (burst_resp) begin
               cnt <= cnt_nxt;
               if (cnt == LAST) begin
                  state       <= DONE;
                  burst_write <= 1'b0;
                  pmem_resp   <= 1'b1;
               end else begin
                  burst_wdata <= next_beat;
               end
            end
            // DONE always falls back to IDLE so a still-held request is not re-accepted.
            DONE: begin
               pmem_resp <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pmem_burst_adaptor.sv
// Directed bench for pmem_burst_adaptor: outputs sampled on the falling edge,
// inputs changed there too so they are settled for the next rising edge.
module tb_pmem_burst_adaptor;
   logic         clk = 1'b0;
   logic         rst_n;
   logic         pmem_read, pmem_write;
   logic [31:0]  pmem_address;
   logic [255:0] pmem_wdata;
   logic         pmem_resp;
   logic [255:0] pmem_rdata;
   logic         burst_read, burst_write;
   logic [31:0]  burst_address;
   logic [63:0]  burst_wdata;
   logic [63:0]  burst_rdata;
   logic         burst_resp;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pmem_burst_adaptor dut (
      .clk(clk), .rst_n(rst_n),
      .pmem_read(pmem_read), .pmem_write(pmem_write),
      .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
      .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
      .burst_read(burst_read), .burst_write(burst_write),
      .burst_address(burst_address), .burst_wdata(burst_wdata),
      .burst_rdata(burst_rdata), .burst_resp(burst_resp)
   );

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   logic [63:0]  rb [4];
   logic [63:0]  rb2 [4];
   logic [63:0]  wb [6];
   logic         wresp [6];
   logic [255:0] line_a, line_b;

   initial begin
      rb  = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
              64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
      rb2 = '{64'hA0A0_0000_0000_0001, 64'hB1B1_0000_0000_0002,
              64'hC2C2_0000_0000_0003, 64'hD3D3_0000_0000_0004};
      wb    = '{64'hA, 64'hB, 64'hC, 64'hC, 64'hC, 64'hD};
      wresp = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      line_a = {rb[3], rb[2], rb[1], rb[0]};
      line_b = {rb2[3], rb2[2], rb2[1], rb2[0]};

      rst_n = 1'b0; pmem_read = 1'b0; pmem_write = 1'b0;
      pmem_address = '0; pmem_wdata = '0; burst_rdata = '0; burst_resp = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_resp",  pmem_resp, 0);
      chk("rst_brd",   burst_read, 0);
      chk("rst_bwr",   burst_write, 0);
      chk("rst_baddr", burst_address, 0);
      chk("rst_bwd",   burst_wdata, 0);
      chk("rst_rdata", pmem_rdata, 0);
      rst_n = 1'b1;

      // Read, zero-wait memory
      pmem_read = 1'b1; pmem_address = 32'h0000_1234;
      for (int b = 0; b < 4; b++) begin
         @(negedge clk);
         chk("rd_busy", burst_read, 1);
         chk("rd_addr", burst_address, 32'h0000_1220);
         chk("rd_noresp", pmem_resp, 0);
         burst_rdata = rb[b]; burst_resp = 1'b1;
      end
      @(negedge clk);
      chk("rd_resp", pmem_resp, 1);
      chk("rd_brd_off", burst_read, 0);
      chk("rd_line", pmem_rdata, line_a);
      pmem_read = 1'b0; burst_resp = 1'b0;
      @(negedge clk);
      chk("rd_resp_pulse", pmem_resp, 0);
      chk("rd_line_hold", pmem_rdata, line_a);

      // Write with a 2-cycle stall before beat 2
      pmem_write = 1'b1; pmem_address = 32'h0000_0060;
      pmem_wdata = {64'hD, 64'hC, 64'hB, 64'hA};
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("wr_busy", burst_write, 1);
         chk("wr_addr", burst_address, 32'h0000_0060);
         chk("wr_beat", burst_wdata, wb[c]);
         chk("wr_noresp", pmem_resp, 0);
         burst_resp = wresp[c];
      end
      @(negedge clk);
      chk("wr_resp", pmem_resp, 1);
      chk("wr_bwr_off", burst_write, 0);
      chk("wr_rdata_kept", pmem_rdata, line_a);
      pmem_write = 1'b0; burst_resp = 1'b0;
      @(negedge clk);
      chk("wr_resp_pulse", pmem_resp, 0);

      // Simultaneous read and write: write wins
      pmem_read = 1'b1; pmem_write = 1'b1; pmem_address = 32'h0000_0100;
      pmem_wdata = {64'h4, 64'h3, 64'h2, 64'h1};
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("rw_bwr", burst_write, 1);
         chk("rw_brd", burst_read, 0);
         chk("rw_beat", burst_wdata, 64'(c + 1));
         burst_resp = 1'b1;
      end
      @(negedge clk);
      chk("rw_resp", pmem_resp, 1);
      chk("rw_rdata_kept", pmem_rdata, line_a);
      pmem_read = 1'b0; pmem_write = 1'b0;
      // burst_resp stays high through IDLE: must be ignored
      @(negedge clk);
      chk("rw_single_resp", pmem_resp, 0);
      chk("idle_brd", burst_read, 0);
      chk("idle_bwr", burst_write, 0);
      burst_resp = 1'b0;

      // Back-to-back reads with one IDLE cycle between them
      pmem_read = 1'b1; pmem_address = 32'h0000_0040;
      for (int b = 0; b < 4; b++) begin
         @(negedge clk);
         burst_rdata = rb2[b]; burst_resp = 1'b1;
      end
      @(negedge clk);
      chk("b2b_resp1", pmem_resp, 1);
      chk("b2b_line1", pmem_rdata, line_b);
      pmem_read = 1'b0; burst_resp = 1'b0;
      @(negedge clk);
      chk("b2b_idle_gap", burst_read, 0);
      pmem_read = 1'b1; pmem_address = 32'h0000_009F;
      @(negedge clk);
      chk("b2b_start", burst_read, 1);
      chk("b2b_addr", burst_address, 32'h0000_0080);
      for (int b = 0; b < 4; b++) begin
         burst_rdata = rb[b]; burst_resp = 1'b1;
         @(negedge clk);
      end
      chk("b2b_resp2", pmem_resp, 1);
      chk("b2b_line2", pmem_rdata, line_a);
      pmem_read = 1'b0; burst_resp = 1'b0;
      @(negedge clk);
      chk("b2b_no_dup", burst_read, 0);

      // Reset after beat 1 of a read
      pmem_read = 1'b1; pmem_address = 32'h0000_0200;
      @(negedge clk);
      burst_rdata = rb2[0]; burst_resp = 1'b1;
      @(negedge clk);
      burst_rdata = rb2[1];
      @(negedge clk);
      burst_resp = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("mrst_brd", burst_read, 0);
      chk("mrst_resp", pmem_resp, 0);
      chk("mrst_rdata", pmem_rdata, 0);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("mrst_restart", burst_read, 1);
      chk("mrst_addr", burst_address, 32'h0000_0200);
      for (int b = 0; b < 4; b++) begin
         burst_rdata = rb[b]; burst_resp = 1'b1;
         @(negedge clk);
      end
      chk("mrst_resp2", pmem_resp, 1);
      chk("mrst_line", pmem_rdata, line_a);
      pmem_read = 1'b0; burst_resp = 1'b0;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pmem_burst_adaptor.md
Name: pmem_burst_adaptor

Overview:
- Sits between the cache's physical-memory port and the burst-oriented main memory.
- Converts one 256-bit line read or write into a 4-beat × 64-bit burst on the memory side.
- Reassembles read beats into a full line and returns a single-cycle completion pulse to the cache.
- Fully registered on both sides; exactly one transaction outstanding at a time.

Parameters:
- LINE_WIDTH, 256, cache line width in bits.
- BEAT_WIDTH, 64, memory data bus width in bits.
- ADDR_WIDTH, 32, byte address width.
- BEATS (localparam), LINE_WIDTH/BEAT_WIDTH = 4, beats per line.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pmem_read  in  1  cache line-read request, held until pmem_resp.
- pmem_write  in  1  cache line-write request, held until pmem_resp.
- pmem_address  in  32  cache request byte address.
- pmem_wdata  in  256  line to write.
- pmem_resp  out  1  one-cycle completion pulse to the cache.
- pmem_rdata  out  256  assembled read line, valid while pmem_resp=1 and held until the next read completes.
- burst_read  out  1  memory burst-read request.
- burst_write  out  1  memory burst-write request.
- burst_address  out  32  line-aligned burst address.
- burst_wdata  out  64  current write beat.
- burst_rdata  in  64  current read beat.
- burst_resp  in  1  memory beat acknowledge; one beat transfers per cycle it is high.

Behaviour:
- Reset (rst_n=0, asynchronous, any time including mid-burst):
  - State returns to IDLE and beat counter clears.
  - pmem_resp, burst_read, burst_write = 0.
  - burst_address, burst_wdata, pmem_rdata = 0.
  - Any in-flight burst is abandoned; no pmem_resp is issued for it.
- States:
  - IDLE
  - RD_BURST
  - WR_BURST
  - DONE
- IDLE:
  - pmem_write=1 → latch {pmem_address[31:5],5'b0} and pmem_wdata; go to WR_BURST.
  - Else pmem_read=1 → latch the aligned address; go to RD_BURST.
  - Write has priority when both requests are high. The read is not serviced unless still asserted after DONE.
  - Requests are sampled only in IDLE. Changes to request inputs in other states are ignored.
- RD_BURST:
  - burst_read=1 and burst_address=latched address, stable for the whole burst.
  - Each cycle with burst_resp=1: burst_rdata goes into line slice [64*cnt +: 64], then cnt increments.
  - Beat 0 maps to bits 63:0 (little-endian beat order).
  - When cnt=3 and burst_resp=1: go to DONE.
- WR_BURST:
  - burst_write=1; burst_wdata = latched line slice [64*cnt +: 64] (registered mux, valid while burst_write=1).
  - cnt advances on burst_resp.
  - When cnt=3 and burst_resp=1: go to DONE.
- Gaps: burst_resp may drop for any number of cycles mid-burst. The counter holds and outputs stay stable.
- DONE:
  - burst_read/burst_write = 0 and pmem_resp=1 for exactly one cycle.
  - pmem_rdata updates only when a read completes; a write leaves it unchanged.
  - Next state is IDLE.
  - The IDLE cycle after DONE is mandatory. It gives the cache one cycle to drop its request, so the same request is never accepted twice.
- Latency with zero-wait memory:
  - Request seen in IDLE at cycle 0.
  - burst_read/burst_write high at cycles 1–4.
  - pmem_resp at cycle 5.
  - Next acceptance no earlier than cycle 6.
  - In general, total latency = 2 + number of cycles with burst_read/burst_write high.
- Address: low 5 bits are always zeroed on burst_address. The counter is 2 bits and wraps only by returning to IDLE, never mid-burst.
- burst_resp outside RD_BURST/WR_BURST is ignored.

Decomposition:
- Shared package pmem_adaptor_types:
  - State enum {IDLE, RD_BURST, WR_BURST, DONE}.
  - LINE_WIDTH/BEAT_WIDTH/BEATS constants.
  - Line-offset width constant OFFSET_BITS=5.
- Single sub-module, line_beat_buffer: 256-bit line register with beat-indexed write (read assembly) and beat-indexed read mux (write serialisation).
- The FSM and counter stay in the top level.

Test Plan:
- Read, zero-wait memory:
  - Stimulus: pmem_read, address 0x0000_1234; memory beats 0x1111…, 0x2222…, 0x3333…, 0x4444… each replicated to 64b.
  - Response: burst_address=0x0000_1220; burst_read high for exactly 4 cycles; pmem_resp at cycle 5; pmem_rdata = {0x4444…,0x3333…,0x2222…,0x1111…}.
- Write with stalls:
  - Stimulus: pmem_write, address 0x0000_0060, wdata = {64'hD,64'hC,64'hB,64'hA}; burst_resp low for 2 cycles before beat 2.
  - Response: burst_wdata sequence A,B,C,D; burst_wdata holds C through the stall; pmem_resp once, at cycle 7.
- Simultaneous read and write:
  - Stimulus: both asserted at address 0x100.
  - Response: write burst only; single pmem_resp; pmem_rdata unchanged.
- Back-to-back:
  - Stimulus: cache drops its request after pmem_resp, then reasserts read on the next cycle.
  - Response: exactly one IDLE cycle between DONE and the next burst_read; no duplicate burst.
- Reset mid-burst:
  - Stimulus: rst_n pulsed low after beat 1 of a read.
  - Response: burst_read=0 and pmem_resp=0 immediately (asynchronous); next read starts cleanly at beat 0 and returns the correct line.
